// File: rtl/conv_psum_accum_ctrl_pkg.sv
// conv_psum_accum_ctrl_pkg: shared FSM encodings and saturation limits for the CNN controllers
package conv_psum_accum_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;
  function automatic logic [63:0] sat_max(input int dw);
    return (64'd1 << (dw - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int dw);
    return 64'd1 << (dw - 1);
  endfunction
endpackage

// File: rtl/conv_psum_accum_ctrl_if.sv
// conv_psum_accum_ctrl_if: operand/result handshake bus (start+bias, in stream, out result, busy)
interface conv_psum_accum_ctrl_if #(parameter int DATA_WIDTH = 32);
  logic start;
  logic [DATA_WIDTH-1:0] bias;
  logic in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic in_ready;
  logic out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic out_ovf;
  logic out_ready;
  logic busy;
  modport master (output start, bias, in_valid, in_data, out_ready,
                  input in_ready, out_valid, out_data, out_ovf, busy);
  modport slave (input start, bias, in_valid, in_data, out_ready,
                 output in_ready, out_valid, out_data, out_ovf, busy);
endinterface

// File: rtl/conv_psum_accum_ctrl_adder.sv
// conv_psum_accum_ctrl_adder: ripple-carry adder s = a + b + cin (ports a, b, cin in; s out)
module conv_psum_accum_ctrl_adder #(parameter int DATA_WIDTH = 32) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] s
);
  logic [DATA_WIDTH-1:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_fa
    assign s[i] = a[i] ^ b[i] ^ c[i];
    if (i < DATA_WIDTH - 1) begin : g_c
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end
endmodule

// File: rtl/conv_psum_accum_ctrl.sv
// conv_psum_accum_ctrl: accumulates NUM_TAPS signed beats onto a bias with saturation (clk, rst, slave bus)
module conv_psum_accum_ctrl
  import conv_psum_accum_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_TAPS   = 9
) (
  input logic clk,
  input logic rst,
  conv_psum_accum_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_TAPS + 1);
  localparam logic [DATA_WIDTH-1:0] SMAX = DATA_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] SMIN = DATA_WIDTH'(sat_min(DATA_WIDTH));
  localparam int M = DATA_WIDTH - 1;
  state_t state;
  logic [DATA_WIDTH-1:0] acc, s, nxt, od;
  logic [CNT_W-1:0] cnt;
  logic ovf, ov, oo;
  conv_psum_accum_ctrl_adder #(.DATA_WIDTH(DATA_WIDTH)) u_add (
    .a(acc), .b(bus.in_data), .cin(1'b0), .s(s)
  );
  always_comb begin
    ov  = (acc[M] == bus.in_data[M]) && (s[M] != acc[M]);
    nxt = ov ? (acc[M] ? SMIN : SMAX) : s;
  end
  assign bus.in_ready  = state == ACCUM;
  assign bus.out_valid = state == DONE;
  assign bus.busy      = state != IDLE;
  assign bus.out_data  = od;
  assign bus.out_ovf   = oo;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      od    <= '0;
      oo    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state <= ACCUM;
          acc   <= bus.bias;
          cnt   <= '0;
          ovf   <= 1'b0;
        end
        ACCUM: if (bus.in_valid) begin
          acc <= nxt;
          cnt <= cnt + CNT_W'(1);
          ovf <= ovf | ov;
          if (cnt == CNT_W'(NUM_TAPS - 1)) begin
            state <= DONE;
            od    <= nxt;
            oo    <= ovf | ov;
          end
        end
        DONE: if (bus.out_ready) begin
          state <= IDLE;
          od    <= '0;
          oo    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_psum_accum_ctrl.sv
// tb_conv_psum_accum_ctrl: scoreboard bench for conv_psum_accum_ctrl
module tb_conv_psum_accum_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  logic [32:0] sb[$];
  always #5 clk = ~clk;
  conv_psum_accum_ctrl_if #(.DATA_WIDTH(32)) bus ();
  conv_psum_accum_ctrl #(.DATA_WIDTH(32), .NUM_TAPS(9)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [32:0] model(input int b, input int v[9]);
    longint a = longint'(b);
    logic o = 1'b0;
    for (int i = 0; i < 9; i++) begin
      a = a + longint'(v[i]);
      if (a > 64'sd2147483647) begin a = 64'sd2147483647; o = 1'b1; end
      else if (a < -64'sd2147483648) begin a = -64'sd2147483648; o = 1'b1; end
    end
    return {o, a[31:0]};
  endfunction
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) chk("sb_empty", 64'(1), 64'(0));
      else begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(e[31:0]));
        chk("out_ovf", 64'(bus.out_ovf), 64'(e[32]));
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_window(input int b, input int v[9], input bit gaps, input int hold, input bit st_hs);
    logic [32:0] e;
    e = model(b, v);
    sb.push_back(e);
    bus.start = 1'b1;
    bus.bias = b;
    step();
    bus.start = 1'b0;
    chk("busy_accum", 64'(bus.busy), 64'(1));
    for (int i = 0; i < 9; i++) begin
      if (gaps && (i % 2 == 1)) begin
        bus.in_valid = 1'b0;
        step();
        chk("stall_valid", 64'(bus.out_valid), 64'(0));
      end
      bus.in_valid = 1'b1;
      bus.in_data = v[i];
      chk("in_ready", 64'(bus.in_ready), 64'(1));
      chk("early_valid", 64'(bus.out_valid), 64'(0));
      step();
    end
    bus.in_valid = 1'b0;
    chk("latency", 64'(bus.out_valid), 64'(1));
    for (int h = 0; h < hold; h++) begin
      bus.start = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data = 32'h1234;
      chk("hold_valid", 64'(bus.out_valid), 64'(1));
      chk("hold_data", 64'(bus.out_data), 64'(e[31:0]));
      chk("hold_ready", 64'(bus.in_ready), 64'(0));
      step();
    end
    bus.start = st_hs;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    bus.start = 1'b0;
    chk("busy_after", 64'(bus.busy), 64'(0));
    chk("valid_after", 64'(bus.out_valid), 64'(0));
    chk("data_idle", 64'(bus.out_data), 64'(0));
    if (st_hs) begin
      step();
      chk("start_ignored", 64'(bus.busy), 64'(0));
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int v[9];
    bus.start = 1'b1;
    bus.bias = 32'd0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'd7;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_ready", 64'(bus.in_ready), 64'(0));
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_data", 64'(bus.out_data), 64'(0));
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    step();
    v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    run_window(10, v, 1'b0, 0, 1'b0);
    v = '{-5, 3, -7, 0, 2, -1, 4, -8, 6};
    run_window(0, v, 1'b1, 0, 1'b0);
    v = '{32, -1, -1, -1, -1, -1, -1, -1, -1};
    run_window(int'(32'h7FFF_FFF0), v, 1'b0, 0, 1'b0);
    v = '{-1, 0, 0, 0, 0, 0, 0, 0, 0};
    run_window(int'(32'h8000_0000), v, 1'b0, 0, 1'b0);
    v = '{100, -3, 250, 7, -40, 11, 0, 5, 9};
    run_window(-17, v, 1'b0, 5, 1'b1);
    bus.start = 1'b1;
    bus.bias = 32'd0;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 32'd2;
      step();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_valid", 64'(bus.out_valid), 64'(0));
    step();
    chk("abort_idle", 64'(bus.busy), 64'(0));
    v = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    run_window(0, v, 1'b0, 0, 1'b0);
    step();
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
